// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard: shadows in-flight register writers from EXE to WB
// and stalls ID when an operand cannot be supplied by the forwarding network.
module hazard_scoreboard #(
    parameter int DEPTH        = 3,
    parameter int FWD_EN       = 1,
    parameter int FLUSH_STAGES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_issue_valid,
    input  logic        i_issue_wb_en,
    input  logic        i_issue_is_ld,
    input  logic [3:0]  i_issue_dest,
    input  logic [3:0]  i_src1,
    input  logic [3:0]  i_src2,
    input  logic        i_two_src,
    input  logic        i_mem_stall,
    input  logic        i_flush,
    output logic        o_hazard,
    output logic        o_issue_fire,
    output logic [15:0] o_pending,
    output logic [2:0]  o_inflight
);

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_wb_en;
    logic [DEPTH-1:0] r_is_ld;
    logic [3:0]       r_dest [DEPTH];
    logic [2:0]       r_inflight;

    logic [DEPTH-1:0] w_match;
    logic [DEPTH-1:0] w_n_vld;
    logic [DEPTH-1:0] w_n_wb_en;
    logic [DEPTH-1:0] w_n_is_ld;
    logic [3:0]       w_n_dest [DEPTH];
    logic [2:0]       w_n_inflight;

    // With forwarding only a load still in EXE cannot supply its result in time.
    always_comb begin
        w_match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_match[k] = r_vld[k] & r_wb_en[k] &
                         ((r_dest[k] == i_src1) | (i_two_src & (r_dest[k] == i_src2)));
        end
        if (FWD_EN != 0) begin
            o_hazard = i_issue_valid & r_is_ld[0] & w_match[0];
        end else begin
            o_hazard = i_issue_valid & (|w_match);
        end
        o_issue_fire = i_issue_valid & ~o_hazard & ~i_mem_stall;
    end

    always_comb begin
        o_pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_vld[k] && r_wb_en[k]) begin
                o_pending[r_dest[k]] = 1'b1;
            end
        end
    end

    // Flush is applied to the post-shift values, so it also kills a new stage-0 entry.
    always_comb begin
        w_n_vld   = r_vld;
        w_n_wb_en = r_wb_en;
        w_n_is_ld = r_is_ld;
        w_n_dest  = r_dest;
        if (!i_mem_stall) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                w_n_vld[k]   = r_vld[k-1];
                w_n_wb_en[k] = r_wb_en[k-1];
                w_n_is_ld[k] = r_is_ld[k-1];
                w_n_dest[k]  = r_dest[k-1];
            end
            w_n_vld[0]   = o_issue_fire;
            w_n_wb_en[0] = o_issue_fire & i_issue_wb_en;
            w_n_is_ld[0] = o_issue_fire & i_issue_is_ld;
            w_n_dest[0]  = o_issue_fire ? i_issue_dest : 4'd0;
        end
        if (i_flush) begin
            for (int k = 0; k < FLUSH_STAGES && k < DEPTH; k++) begin
                w_n_vld[k]   = 1'b0;
                w_n_wb_en[k] = 1'b0;
                w_n_is_ld[k] = 1'b0;
                w_n_dest[k]  = 4'd0;
            end
        end
        w_n_inflight = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_n_inflight = w_n_inflight + {2'b00, w_n_vld[k] & w_n_wb_en[k]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld      <= '0;
            r_wb_en    <= '0;
            r_is_ld    <= '0;
            r_inflight <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_dest[k] <= 4'd0;
            end
        end else begin
            r_vld      <= w_n_vld;
            r_wb_en    <= w_n_wb_en;
            r_is_ld    <= w_n_is_ld;
            r_inflight <= w_n_inflight;
            for (int k = 0; k < DEPTH; k++) begin
                r_dest[k] <= w_n_dest[k];
            end
        end
    end

    assign o_inflight = r_inflight;

endmodule
